// File: rtl/bsram_save_ctrl.sv
// Backup-RAM save/load sequencer between dual-port BSRAM and the hps_io SD image interface.
// Optional macro BSRAM_AUTOSAVE_EN: an OSD-open rising edge saves dirty BSRAM automatically.
module bsram_save_ctrl #(
    parameter int          BSRAM_BITS  = 16,
    parameter logic [21:0] ACK_TIMEOUT = 22'h3FFFFF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [23:0] ram_mask,
    input  logic        rom_download,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic        img_size_nz,
    input  logic        load_req,
    input  logic        save_req,
    input  logic        osd_open,
    input  logic        bsram_we,
    input  logic        sd_ack,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        bk_ena,
    output logic        bk_loading,
    output logic        busy,
    output logic        dirty,
    output logic        error
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, XFER = 2'd2} state_t;

    localparam logic [14:0] LAST_CAP = 15'((32'd1 << (BSRAM_BITS - 9)) - 32'd1);

    state_t      state_q, state_d;
    logic [31:0] sd_lba_q, sd_lba_d;
    logic [21:0] cnt_q, cnt_d;
    logic        sd_rd_q, sd_rd_d;
    logic        sd_wr_q, sd_wr_d;
    logic        bk_ena_q, bk_ena_d;
    logic        bk_loading_q, bk_loading_d;
    logic        dirty_q, dirty_d;
    logic        error_q, error_d;
    logic        mode_load_q, mode_load_d;

    // Delayed input copies for edge detection
    logic        rom_dl_q, load_req_q, save_req_q, sd_ack_q;

    logic        rom_rise, rom_fall, load_rise, save_rise, ack_rise, ack_fall;
    logic        auto_save, load_start, save_start;
    logic [14:0] last;

    assign rom_rise  = rom_download & ~rom_dl_q;
    assign rom_fall  = ~rom_download & rom_dl_q;
    assign load_rise = load_req & ~load_req_q;
    assign save_rise = save_req & ~save_req_q;
    assign ack_rise  = sd_ack & ~sd_ack_q;
    assign ack_fall  = ~sd_ack & sd_ack_q;

`ifdef BSRAM_AUTOSAVE_EN
    logic osd_open_q;
    assign auto_save = osd_open & ~osd_open_q & dirty_q & ~error_q;
`else
    logic unused_osd_open;
    assign unused_osd_open = osd_open;
    assign auto_save       = 1'b0;
`endif

    // Load has priority; a save colliding with a load is dropped, not deferred
    assign load_start = bk_ena_q & (rom_fall | load_rise);
    assign save_start = bk_ena_q & (save_rise | auto_save) & ~load_start;

    always_comb begin
        last = ram_mask[23:9];
        if (ram_mask[23:9] > LAST_CAP) begin
            last = LAST_CAP;
        end
    end

    always_comb begin
        state_d      = state_q;
        sd_lba_d     = sd_lba_q;
        cnt_d        = cnt_q;
        sd_rd_d      = sd_rd_q;
        sd_wr_d      = sd_wr_q;
        bk_ena_d     = bk_ena_q;
        bk_loading_d = bk_loading_q;
        dirty_d      = dirty_q;
        error_d      = error_q;
        mode_load_d  = mode_load_q;

        if (rom_rise) begin
            bk_ena_d = 1'b0;
            dirty_d  = 1'b0;
        end
        if (rom_download && img_mounted && img_size_nz && !img_readonly) begin
            bk_ena_d = |ram_mask;
        end

        case (state_q)
            IDLE: begin
                if (load_start || save_start) begin
                    sd_lba_d     = 32'd0;
                    mode_load_d  = load_start;
                    bk_loading_d = load_start;
                    sd_rd_d      = load_start;
                    sd_wr_d      = ~load_start;
                    cnt_d        = 22'd0;
                    error_d      = 1'b0;
                    state_d      = ISSUE;
                    if (save_start) begin
                        dirty_d = 1'b0;
                    end
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 22'd1;
                if (ack_rise) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    state_d = XFER;
                end else if (cnt_d == ACK_TIMEOUT) begin
                    sd_rd_d      = 1'b0;
                    sd_wr_d      = 1'b0;
                    error_d      = 1'b1;
                    bk_loading_d = 1'b0;
                    state_d      = IDLE;
                    // The image was not fully written, so the RAM is still unsaved
                    if (!mode_load_q) begin
                        dirty_d = 1'b1;
                    end
                end
            end
            XFER: begin
                if (ack_fall) begin
                    if (sd_lba_q == {17'd0, last}) begin
                        bk_loading_d = 1'b0;
                        state_d      = IDLE;
                        if (mode_load_q) begin
                            dirty_d = 1'b0;
                        end
                    end else begin
                        sd_lba_d = sd_lba_q + 32'd1;
                        sd_rd_d  = mode_load_q;
                        sd_wr_d  = ~mode_load_q;
                        cnt_d    = 22'd0;
                        state_d  = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Core writes win over any clear so a write racing a save is never lost
        if (bsram_we && !bk_loading_q) begin
            dirty_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            state_q      <= IDLE;
            sd_lba_q     <= 32'd0;
            cnt_q        <= 22'd0;
            sd_rd_q      <= 1'b0;
            sd_wr_q      <= 1'b0;
            bk_ena_q     <= 1'b0;
            bk_loading_q <= 1'b0;
            dirty_q      <= 1'b0;
            error_q      <= 1'b0;
            mode_load_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sd_lba_q     <= sd_lba_d;
            cnt_q        <= cnt_d;
            sd_rd_q      <= sd_rd_d;
            sd_wr_q      <= sd_wr_d;
            bk_ena_q     <= bk_ena_d;
            bk_loading_q <= bk_loading_d;
            dirty_q      <= dirty_d;
            error_q      <= error_d;
            mode_load_q  <= mode_load_d;
        end
        rom_dl_q   <= rom_download;
        load_req_q <= load_req;
        save_req_q <= save_req;
        sd_ack_q   <= sd_ack;
`ifdef BSRAM_AUTOSAVE_EN
        osd_open_q <= osd_open;
`endif
    end

    assign sd_lba     = sd_lba_q;
    assign sd_rd      = sd_rd_q;
    assign sd_wr      = sd_wr_q;
    assign bk_ena     = bk_ena_q;
    assign bk_loading = bk_loading_q;
    assign busy       = (state_q != IDLE);
    assign dirty      = dirty_q;
    assign error      = error_q;
endmodule

// File: tb/tb_bsram_save_ctrl.sv
// Directed + randomized bench for bsram_save_ctrl with an SD host responder and sector-list model.
module tb_bsram_save_ctrl;
    localparam int BITS = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] ram_mask;
    logic        rom_download, img_mounted, img_readonly, img_size_nz;
    logic        load_req, save_req, osd_open, bsram_we, sd_ack;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, bk_ena, bk_loading, busy, dirty, error;

    int total = 0;
    int bad = 0;
    int viol = 0;
    int both_cnt = 0;
    bit host_en = 1'b1;
    bit          kq[$];
    logic [31:0] lq[$];

    always #5 clk = ~clk;

    bsram_save_ctrl #(.BSRAM_BITS(BITS), .ACK_TIMEOUT(22'd16)) dut (
        .clk_sys(clk), .reset(reset), .ram_mask(ram_mask),
        .rom_download(rom_download), .img_mounted(img_mounted),
        .img_readonly(img_readonly), .img_size_nz(img_size_nz),
        .load_req(load_req), .save_req(save_req), .osd_open(osd_open),
        .bsram_we(bsram_we), .sd_ack(sd_ack), .sd_lba(sd_lba),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .bk_ena(bk_ena), .bk_loading(bk_loading),
        .busy(busy), .dirty(dirty), .error(error)
    );

    always @(negedge clk) begin
        if (sd_rd && sd_wr) both_cnt++;
    end

    // SD host: records each request, acks after a random delay, drops ack after the request falls
    initial begin : host
        logic [31:0] lba0;
        int n;
        sd_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (host_en && (sd_rd || sd_wr)) begin
                kq.push_back(sd_wr);
                lq.push_back(sd_lba);
                lba0 = sd_lba;
                repeat ($urandom_range(1, 6)) begin
                    @(negedge clk);
                    if ((sd_rd || sd_wr) && sd_lba !== lba0) viol++;
                end
                sd_ack = 1'b1;
                n = 0;
                while ((sd_rd || sd_wr) && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 50) viol++;
                repeat ($urandom_range(0, 4)) @(negedge clk);
                sd_ack = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Number of sectors one transfer must move for a given mask
    function automatic int exp_count(input logic [23:0] m);
        int s = int'(m >> 9);
        int cap = (1 << (BITS - 9)) - 1;
        return ((s > cap) ? cap : s) + 1;
    endfunction

    task automatic wait_idle(input string tag);
        int c = 0;
        while (busy && c < 5000) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_xfers(input string tag, input bit is_wr, input logic [23:0] m);
        int n = exp_count(m);
        chk({tag, "_count"}, 32'(kq.size()), 32'(n));
        for (int i = 0; i < n && i < kq.size(); i++) begin
            chk({tag, "_kind"}, 32'(kq[i]), 32'(is_wr));
            chk({tag, "_lba"}, lq[i], 32'(i));
        end
        $display("xfer %s: %s mask=%06h sectors=%0d", tag, is_wr ? "save" : "load", m, kq.size());
        kq.delete();
        lq.delete();
    endtask

    task automatic mount_rw();
        img_readonly = 1'b0;
        img_size_nz  = 1'b1;
        img_mounted  = 1'b1;
        tick(1);
        img_mounted  = 1'b0;
        tick(1);
    endtask

    initial begin
        logic [23:0] m;
        bit do_load;
        int cyc;

        reset = 1'b0; ram_mask = 24'h0; rom_download = 1'b0; img_mounted = 1'b0;
        img_readonly = 1'b0; img_size_nz = 1'b0; load_req = 1'b0; save_req = 1'b0;
        osd_open = 1'b0; bsram_we = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
        chk("rst_rd", 32'(sd_rd), 0); chk("rst_wr", 32'(sd_wr), 0);
        chk("rst_lba", sd_lba, 0); chk("rst_bk_ena", 32'(bk_ena), 0);
        chk("rst_loading", 32'(bk_loading), 0); chk("rst_busy", 32'(busy), 0);
        chk("rst_dirty", 32'(dirty), 0); chk("rst_error", 32'(error), 0);

        // Read-only mount must not enable the save file; writable mount must
        rom_download = 1'b1; ram_mask = 24'h1FFF;
        tick(1);
        img_readonly = 1'b1; img_size_nz = 1'b1; img_mounted = 1'b1;
        tick(1);
        img_mounted = 1'b0;
        tick(1);
        chk("bk_ena_ro", 32'(bk_ena), 0);
        mount_rw();
        chk("bk_ena_rw", 32'(bk_ena), 1);

        // Auto-load after download
        rom_download = 1'b0;
        tick(1);
        chk("al_loading", 32'(bk_loading), 1); chk("al_busy", 32'(busy), 1);
        chk("al_rd", 32'(sd_rd), 1);
        wait_idle("autoload");
        check_xfers("autoload", 1'b0, ram_mask);
        chk("al_loading_end", 32'(bk_loading), 0); chk("al_dirty", 32'(dirty), 0);

        // Manual save with a write landing mid-save
        bsram_we = 1'b1; tick(1); bsram_we = 1'b0;
        chk("we_dirty", 32'(dirty), 1);
        ram_mask = 24'h7FF;
        save_req = 1'b1; tick(1); save_req = 0;
        chk("sv_busy", 32'(busy), 1); chk("sv_dirty_clr", 32'(dirty), 0);
        chk("sv_wr", 32'(sd_wr), 1); chk("sv_rd", 32'(sd_rd), 0);
        tick(3);
        bsram_we = 1'b1; tick(1); bsram_we = 1'b0;
        wait_idle("save");
        check_xfers("save", 1'b1, ram_mask);
        chk("sv_dirty_kept", 32'(dirty), 1);

        // Randomized transfers including the sector cap and sub-sector mask
        for (int i = 0; i < 6; i++) begin
            if (i == 0) m = 24'hFFFFF;
            else if (i == 1) m = 24'h1FF;
            else m = 24'(($urandom & 32'hFFFFFF) >> $urandom_range(4, 23));
            do_load = (i == 0) ? 1'b0 : 1'(($urandom_range(0, 1)));
            ram_mask = m;
            if (do_load) load_req = 1'b1; else save_req = 1'b1;
            tick(1);
            load_req = 1'b0; save_req = 1'b0;
            wait_idle("rand");
            check_xfers("rand", !do_load, m);
            chk("rand_dirty", 32'(dirty), 0); chk("rand_error", 32'(error), 0);
        end

        // Simultaneous requests: load wins; save while busy is ignored
        ram_mask = 24'h5FF;
        load_req = 1'b1; save_req = 1'b1; tick(1); load_req = 1'b0;
        tick(2);
        save_req = 1'b0; tick(1);
        chk("both_busy", 32'(busy), 1);
        save_req = 1'b1; tick(1);
        wait_idle("both");
        tick(3);
        chk("both_no_requeue", 32'(busy), 0);
        check_xfers("both", 1'b0, ram_mask);
        save_req = 1'b0;

        // Ack timeout during a load
        host_en = 1'b0;
        ram_mask = 24'h7FF;
        load_req = 1'b1; tick(1); load_req = 1'b0;
        chk("to_rd", 32'(sd_rd), 1);
        cyc = 0;
        while (busy && cyc < 100) begin
            tick(1);
            cyc++;
        end
        chk("to_cycles", 32'(cyc), 16);
        chk("to_error", 32'(error), 1); chk("to_loading", 32'(bk_loading), 0);
        chk("to_rd_off", 32'(sd_rd), 0); chk("to_no_xfer", 32'(kq.size()), 0);

        // Next start clears error; an aborted save leaves dirty set
        save_req = 1'b1; tick(1); save_req = 1'b0;
        chk("tos_error_clr", 32'(error), 0); chk("tos_wr", 32'(sd_wr), 1);
        wait_idle("tosave");
        chk("tos_error", 32'(error), 1); chk("tos_dirty", 32'(dirty), 1);
        chk("tos_wr_off", 32'(sd_wr), 0);
        host_en = 1'b1;

`ifdef BSRAM_AUTOSAVE_EN
        osd_open = 1'b1; tick(2);
        chk("as_err_block", 32'(busy), 0);
        osd_open = 1'b0;
        save_req = 1'b1; tick(1); save_req = 1'b0;
        wait_idle("as_clear");
        check_xfers("as_clear", 1'b1, ram_mask);
        bsram_we = 1'b1; tick(1); bsram_we = 1'b0;
        chk("as_dirty", 32'(dirty), 1);
        osd_open = 1'b1; tick(1);
        chk("as_busy", 32'(busy), 1);
        wait_idle("autosave");
        check_xfers("autosave", 1'b1, ram_mask);
        chk("as_dirty_clr", 32'(dirty), 0);
        osd_open = 1'b0; tick(1);
        osd_open = 1'b1; tick(2);
        chk("as_clean_idle", 32'(busy), 0);
        chk("as_clean_none", 32'(kq.size()), 0);
        osd_open = 1'b0;
`else
        osd_open = 1'b1; tick(2);
        chk("osd_ignored", 32'(busy), 0);
        osd_open = 1'b0; tick(1);
`endif

        // Download start drops bk_ena and dirty; no auto-load without a mount
        bsram_we = 1'b1; tick(1); bsram_we = 1'b0;
        rom_download = 1'b1; tick(1);
        chk("dl_bk_ena", 32'(bk_ena), 0); chk("dl_dirty", 32'(dirty), 0);
        rom_download = 1'b0; tick(2);
        chk("dl_no_load", 32'(busy), 0);

        // Reset mid-transfer aborts immediately
        rom_download = 1'b1; tick(1);
        mount_rw();
        rom_download = 1'b0; tick(1);
        chk("mr_rd", 32'(sd_rd), 1);
        reset = 1'b0; tick(1);
        chk("mr_rd_off", 32'(sd_rd), 0); chk("mr_busy", 32'(busy), 0);
        chk("mr_loading", 32'(bk_loading), 0); chk("mr_bk_ena", 32'(bk_ena), 0);
        reset = 1'b1; tick(20);
        chk("mr_quiet", 32'(sd_rd | sd_wr | busy), 0);
        kq.delete();
        lq.delete();

        chk("lba_stable", 32'(viol), 0);
        chk("rd_wr_excl", 32'(both_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
